// File: rtl/i2c_byte_wr_ctrl.sv
// Write-data stage of the I2C master byte layer: pops bytes from the write FIFO,
// serialises them MSB-first into bit commands and collects the slave ACK per byte.
module i2c_byte_wr_ctrl #(
  parameter int LEN_W = 24
) (
  input  logic             clock,
  input  logic             rst_n,
  input  logic             exec_wr,
  input  logic [LEN_W-1:0] exec_wr_len,
  output logic             exec_wr_finish,
  output logic             exec_wr_nack,
  output logic [LEN_W-1:0] bytes_done,
  output logic             wfifo_rd_en,
  input  logic [7:0]       wfifo_data,
  input  logic             wfifo_empty,
  output logic             tras_cmd_vld,
  output logic [2:0]       tras_cmd,
  input  logic             tras_cmd_ready,
  input  logic             rx_bit_vld,
  input  logic             rx_bit
);

  localparam logic [2:0] CMD_IDLE = 3'd0;
  localparam logic [2:0] CMD_1    = 3'd2;
  localparam logic [2:0] CMD_0    = 3'd3;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_LOAD     = 3'd2,
    ST_SEND     = 3'd3,
    ST_ACK_CMD  = 3'd4,
    ST_ACK_WAIT = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             exec_wr_d_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] bytes_done_r;
  logic [LEN_W-1:0] bytes_inc_s;
  logic             nack_r;
  logic [7:0]       shreg_r;
  logic [2:0]       bit_cnt_r;

  logic start_s;
  logic abort_s;
  logic load_s;
  logic shift_s;
  logic ack_ok_s;
  logic nack_s;

  assign start_s     = (state_r == ST_IDLE) && exec_wr && !exec_wr_d_r;
  assign bytes_inc_s = bytes_done_r + {{(LEN_W-1){1'b0}}, 1'b1};

  // Next-state decode, per-state outputs and datapath enables.
  always_comb begin
    state_nxt_s    = state_r;
    abort_s        = 1'b0;
    load_s         = 1'b0;
    shift_s        = 1'b0;
    ack_ok_s       = 1'b0;
    nack_s         = 1'b0;
    wfifo_rd_en    = 1'b0;
    tras_cmd_vld   = 1'b0;
    tras_cmd       = CMD_IDLE;
    exec_wr_finish = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start_s) begin
          state_nxt_s = (exec_wr_len == {LEN_W{1'b0}}) ? ST_DONE : ST_FETCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_FETCH: begin
        wfifo_rd_en = !wfifo_empty;
        if (!exec_wr) begin
          abort_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (!wfifo_empty) begin
          state_nxt_s = ST_LOAD;
        end else begin
          state_nxt_s = ST_FETCH;
        end
      end
      ST_LOAD: begin
        if (!exec_wr) begin
          abort_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          load_s      = 1'b1;
          state_nxt_s = ST_SEND;
        end
      end
      ST_SEND: begin
        tras_cmd_vld = 1'b1;
        tras_cmd     = shreg_r[7] ? CMD_1 : CMD_0;
        if (!exec_wr) begin
          abort_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (tras_cmd_ready && (bit_cnt_r == 3'd0)) begin
          state_nxt_s = ST_ACK_CMD;
        end else if (tras_cmd_ready) begin
          shift_s = 1'b1;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_ACK_CMD: begin
        // A released SDA during the ACK slot is a plain CMD_1.
        tras_cmd_vld = 1'b1;
        tras_cmd     = CMD_1;
        if (!exec_wr) begin
          abort_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (tras_cmd_ready) begin
          state_nxt_s = ST_ACK_WAIT;
        end else begin
          state_nxt_s = ST_ACK_CMD;
        end
      end
      ST_ACK_WAIT: begin
        if (!exec_wr) begin
          abort_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (rx_bit_vld && rx_bit) begin
          nack_s      = 1'b1;
          state_nxt_s = ST_DONE;
        end else if (rx_bit_vld) begin
          ack_ok_s    = 1'b1;
          state_nxt_s = (bytes_inc_s == len_r) ? ST_DONE : ST_FETCH;
        end else begin
          state_nxt_s = ST_ACK_WAIT;
        end
      end
      ST_DONE: begin
        exec_wr_finish = 1'b1;
        state_nxt_s    = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State register and burst datapath.
  always_ff @(posedge clock) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      exec_wr_d_r  <= 1'b0;
      len_r        <= {LEN_W{1'b0}};
      bytes_done_r <= {LEN_W{1'b0}};
      nack_r       <= 1'b0;
      shreg_r      <= 8'h00;
      bit_cnt_r    <= 3'd0;
    end else begin
      state_r     <= state_nxt_s;
      exec_wr_d_r <= exec_wr;
      if (start_s) begin
        len_r        <= exec_wr_len;
        bytes_done_r <= {LEN_W{1'b0}};
        nack_r       <= 1'b0;
      end else if (ack_ok_s) begin
        bytes_done_r <= bytes_inc_s;
      end else if (nack_s) begin
        nack_r <= 1'b1;
      end
      if (load_s) begin
        shreg_r   <= wfifo_data;
        bit_cnt_r <= 3'd7;
      end else if (shift_s) begin
        shreg_r   <= {shreg_r[6:0], 1'b0};
        bit_cnt_r <= bit_cnt_r - 3'd1;
      end
    end
  end

  assign bytes_done   = bytes_done_r;
  assign exec_wr_nack = nack_r;

endmodule

// File: tb/tb_i2c_byte_wr_ctrl.sv
// Directed bench for i2c_byte_wr_ctrl: a queue-backed FIFO and a bit-layer stub
// with programmable ready pattern and per-byte ACK/NACK responses.
module tb_i2c_byte_wr_ctrl;
  localparam int LEN_W = 24;
  localparam int BOUND = 300;

  logic             clock = 1'b0;
  logic             rst_n;
  logic             exec_wr;
  logic [LEN_W-1:0] exec_wr_len;
  logic             exec_wr_finish;
  logic             exec_wr_nack;
  logic [LEN_W-1:0] bytes_done;
  logic             wfifo_rd_en;
  logic [7:0]       wfifo_data;
  logic             wfifo_empty;
  logic             tras_cmd_vld;
  logic [2:0]       tras_cmd;
  logic             tras_cmd_ready;
  logic             rx_bit_vld;
  logic             rx_bit;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [7:0] fq[$];
  logic [2:0] cmd_log[$];
  int   pops, fin, fin_cyc, pop_cyc, first_cmd_cyc, acc, hold_bad, enc_bad;
  logic pop_pend, ack_due, ack_val, hold_pend, rdy_mode;
  logic [2:0] hold_cmd;
  logic [7:0] ack_pat;

  always #5 clock = ~clock;

  i2c_byte_wr_ctrl #(.LEN_W(LEN_W)) dut (
    .clock(clock), .rst_n(rst_n), .exec_wr(exec_wr), .exec_wr_len(exec_wr_len),
    .exec_wr_finish(exec_wr_finish), .exec_wr_nack(exec_wr_nack), .bytes_done(bytes_done),
    .wfifo_rd_en(wfifo_rd_en), .wfifo_data(wfifo_data), .wfifo_empty(wfifo_empty),
    .tras_cmd_vld(tras_cmd_vld), .tras_cmd(tras_cmd), .tras_cmd_ready(tras_cmd_ready),
    .rx_bit_vld(rx_bit_vld), .rx_bit(rx_bit)
  );

  task automatic env_clear();
    pops = 0; fin = 0; fin_cyc = -1; pop_cyc = -1; first_cmd_cyc = -1;
    acc = 0; hold_bad = 0; enc_bad = 0;
    hold_pend = 1'b0; ack_due = 1'b0; pop_pend = 1'b0;
    cmd_log.delete();
  endtask

  // One clock: FIFO pops and responses land just after the edge, outputs sampled at negedge.
  task automatic env_cycle();
    @(posedge clock);
    #1;
    cyc++;
    if (pop_pend && fq.size() > 0) wfifo_data = fq.pop_front();
    pop_pend    = 1'b0;
    wfifo_empty = (fq.size() == 0);
    rx_bit_vld  = ack_due;
    rx_bit      = ack_due ? ack_val : 1'b0;
    ack_due     = 1'b0;
    tras_cmd_ready = rdy_mode ? ((cyc % 3) == 0) : 1'b1;
    @(negedge clock);
    if (wfifo_rd_en === 1'b1) begin
      pop_pend = 1'b1; pops++; pop_cyc = cyc;
    end
    if (exec_wr_finish === 1'b1) begin
      fin++; fin_cyc = cyc;
    end
    if (tras_cmd_vld !== 1'b1 && tras_cmd !== 3'd0) enc_bad++;
    if (hold_pend && !(tras_cmd_vld === 1'b1 && tras_cmd === hold_cmd)) hold_bad++;
    hold_pend = (tras_cmd_vld === 1'b1) && !tras_cmd_ready;
    hold_cmd  = tras_cmd;
    if (tras_cmd_vld === 1'b1 && tras_cmd_ready) begin
      cmd_log.push_back(tras_cmd);
      if (first_cmd_cyc < 0) first_cmd_cyc = cyc;
      acc++;
      if ((acc % 9) == 0) begin
        ack_due = 1'b1;
        ack_val = ack_pat[(acc / 9) - 1];
      end
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) env_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_cycles(3);
    checks++; if (tras_cmd_vld !== 1'b0) begin errors++; $display("FAIL reset_vld got %b want 0", tras_cmd_vld); end
    checks++; if (tras_cmd !== 3'd0) begin errors++; $display("FAIL reset_cmd got %0d want 0", tras_cmd); end
    checks++; if (wfifo_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", wfifo_rd_en); end
    checks++; if (exec_wr_finish !== 1'b0) begin errors++; $display("FAIL reset_finish got %b want 0", exec_wr_finish); end
    checks++; if (exec_wr_nack !== 1'b0) begin errors++; $display("FAIL reset_nack got %b want 0", exec_wr_nack); end
    checks++; if (bytes_done !== 24'd0) begin errors++; $display("FAIL reset_bytes_done got %0d want 0", bytes_done); end
    rst_n = 1'b1;
    idle_cycles(2);
  endtask

  task automatic test_single_byte();
    logic [2:0] exp [9];
    int t0;
    exp = '{3'd2, 3'd3, 3'd2, 3'd3, 3'd3, 3'd2, 3'd3, 3'd2, 3'd2};
    env_clear();
    fq.push_back(8'hA5); ack_pat = 8'h00; rdy_mode = 1'b0;
    idle_cycles(1);
    exec_wr_len = 24'd1; exec_wr = 1'b1; t0 = cyc;
    for (int k = 0; k < BOUND && fin == 0; k++) env_cycle();
    idle_cycles(4);
    checks++; if (fin !== 1) begin errors++; $display("FAIL single_finish_count got %0d want 1", fin); end
    checks++; if (fin_cyc !== t0 + 13) begin errors++; $display("FAIL single_finish_cycle got %0d want %0d", fin_cyc - t0, 13); end
    checks++; if (pop_cyc !== t0 + 1) begin errors++; $display("FAIL single_pop_cycle got %0d want 1", pop_cyc - t0); end
    checks++; if (first_cmd_cyc !== t0 + 3) begin errors++; $display("FAIL single_first_cmd got %0d want 3", first_cmd_cyc - t0); end
    checks++; if (pops !== 1) begin errors++; $display("FAIL single_pops got %0d want 1", pops); end
    checks++;
    if (cmd_log.size() !== 9) begin
      errors++; $display("FAIL single_cmd_count got %0d want 9", cmd_log.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (cmd_log[i] !== exp[i]) begin errors++; $display("FAIL single_cmd[%0d] got %0d want %0d", i, cmd_log[i], exp[i]); end
      end
    end
    checks++; if (bytes_done !== 24'd1) begin errors++; $display("FAIL single_bytes_done got %0d want 1", bytes_done); end
    checks++; if (exec_wr_nack !== 1'b0) begin errors++; $display("FAIL single_nack got %b want 0", exec_wr_nack); end
    exec_wr = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_backpressure();
    logic [2:0] e;
    env_clear();
    fq.push_back(8'h00); fq.push_back(8'hFF); ack_pat = 8'h00; rdy_mode = 1'b1;
    idle_cycles(1);
    exec_wr_len = 24'd2; exec_wr = 1'b1;
    for (int k = 0; k < BOUND && fin == 0; k++) env_cycle();
    idle_cycles(2);
    checks++; if (fin !== 1) begin errors++; $display("FAIL bp_finish_count got %0d want 1", fin); end
    checks++; if (hold_bad !== 0) begin errors++; $display("FAIL bp_hold_stable got %0d violations want 0", hold_bad); end
    checks++; if (enc_bad !== 0) begin errors++; $display("FAIL bp_idle_encoding got %0d violations want 0", enc_bad); end
    checks++;
    if (cmd_log.size() !== 18) begin
      errors++; $display("FAIL bp_cmd_count got %0d want 18", cmd_log.size());
    end else begin
      for (int i = 0; i < 18; i++) begin
        e = (i < 8) ? 3'd3 : 3'd2;
        checks++;
        if (cmd_log[i] !== e) begin errors++; $display("FAIL bp_cmd[%0d] got %0d want %0d", i, cmd_log[i], e); end
      end
    end
    checks++; if (bytes_done !== 24'd2) begin errors++; $display("FAIL bp_bytes_done got %0d want 2", bytes_done); end
    checks++; if (pops !== 2) begin errors++; $display("FAIL bp_pops got %0d want 2", pops); end
    exec_wr = 1'b0; rdy_mode = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_nack();
    env_clear();
    fq.push_back(8'h11); fq.push_back(8'h22); fq.push_back(8'h33);
    ack_pat = 8'h01; rdy_mode = 1'b0;
    idle_cycles(1);
    exec_wr_len = 24'd3; exec_wr = 1'b1;
    for (int k = 0; k < BOUND && fin == 0; k++) env_cycle();
    idle_cycles(4);
    checks++; if (fin !== 1) begin errors++; $display("FAIL nack_finish_count got %0d want 1", fin); end
    checks++; if (exec_wr_nack !== 1'b1) begin errors++; $display("FAIL nack_flag got %b want 1", exec_wr_nack); end
    checks++; if (bytes_done !== 24'd0) begin errors++; $display("FAIL nack_bytes_done got %0d want 0", bytes_done); end
    checks++; if (pops !== 1) begin errors++; $display("FAIL nack_pops got %0d want 1", pops); end
    checks++; if (fq.size() !== 2) begin errors++; $display("FAIL nack_fifo_left got %0d want 2", fq.size()); end
    checks++; if (cmd_log.size() !== 9) begin errors++; $display("FAIL nack_cmd_count got %0d want 9", cmd_log.size()); end
    exec_wr = 1'b0; ack_pat = 8'h00;
    fq.delete();
    idle_cycles(2);
  endtask

  task automatic test_empty_stall();
    logic [2:0] exp [9];
    exp = '{3'd3, 3'd3, 3'd2, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd2};
    env_clear();
    idle_cycles(1);
    exec_wr_len = 24'd1; exec_wr = 1'b1;
    idle_cycles(20);
    checks++; if (pops !== 0) begin errors++; $display("FAIL stall_pops got %0d want 0", pops); end
    checks++; if (acc !== 0) begin errors++; $display("FAIL stall_cmds got %0d want 0", acc); end
    fq.push_back(8'h3C);
    for (int k = 0; k < BOUND && fin == 0; k++) env_cycle();
    idle_cycles(2);
    checks++; if (fin !== 1) begin errors++; $display("FAIL stall_finish_count got %0d want 1", fin); end
    checks++; if (pops !== 1) begin errors++; $display("FAIL stall_pops_after got %0d want 1", pops); end
    checks++; if (first_cmd_cyc - pop_cyc !== 2) begin errors++; $display("FAIL stall_pop_to_cmd got %0d want 2", first_cmd_cyc - pop_cyc); end
    checks++;
    if (cmd_log.size() !== 9) begin
      errors++; $display("FAIL stall_cmd_count got %0d want 9", cmd_log.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (cmd_log[i] !== exp[i]) begin errors++; $display("FAIL stall_cmd[%0d] got %0d want %0d", i, cmd_log[i], exp[i]); end
      end
    end
    checks++; if (bytes_done !== 24'd1) begin errors++; $display("FAIL stall_bytes_done got %0d want 1", bytes_done); end
    exec_wr = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_zero_len_retrigger();
    int t0;
    env_clear();
    idle_cycles(1);
    exec_wr_len = 24'd0; exec_wr = 1'b1; t0 = cyc;
    idle_cycles(12);
    checks++; if (fin !== 1) begin errors++; $display("FAIL zero_finish_count got %0d want 1", fin); end
    checks++; if (fin_cyc !== t0 + 1) begin errors++; $display("FAIL zero_finish_cycle got %0d want 1", fin_cyc - t0); end
    checks++; if (pops !== 0) begin errors++; $display("FAIL zero_pops got %0d want 0", pops); end
    checks++; if (acc !== 0) begin errors++; $display("FAIL zero_cmds got %0d want 0", acc); end
    exec_wr = 1'b0;
    idle_cycles(1);
    exec_wr = 1'b1; t0 = cyc;
    idle_cycles(4);
    checks++; if (fin !== 2) begin errors++; $display("FAIL retrig_finish_count got %0d want 2", fin); end
    checks++; if (fin_cyc !== t0 + 1) begin errors++; $display("FAIL retrig_finish_cycle got %0d want 1", fin_cyc - t0); end
    exec_wr = 1'b0;
    idle_cycles(2);
  endtask

  task automatic test_abort();
    env_clear();
    fq.push_back(8'hF0); fq.push_back(8'h0F); fq.push_back(8'hAA); fq.push_back(8'h55);
    idle_cycles(1);
    exec_wr_len = 24'd4; exec_wr = 1'b1;
    idle_cycles(16);
    checks++; if (tras_cmd_vld !== 1'b1) begin errors++; $display("FAIL abort_pre_vld got %b want 1", tras_cmd_vld); end
    exec_wr = 1'b0;
    env_cycle();
    checks++; if (tras_cmd_vld !== 1'b0) begin errors++; $display("FAIL abort_vld got %b want 0", tras_cmd_vld); end
    checks++; if (tras_cmd !== 3'd0) begin errors++; $display("FAIL abort_cmd got %0d want 0", tras_cmd); end
    idle_cycles(5);
    checks++; if (fin !== 0) begin errors++; $display("FAIL abort_finish got %0d want 0", fin); end
    checks++; if (bytes_done !== 24'd1) begin errors++; $display("FAIL abort_bytes_done got %0d want 1", bytes_done); end
    checks++; if (pops !== 2) begin errors++; $display("FAIL abort_pops got %0d want 2", pops); end
    fq.delete();
    idle_cycles(2);
  endtask

  task automatic test_reset_mid();
    env_clear();
    fq.push_back(8'hC3); fq.push_back(8'h81);
    idle_cycles(1);
    exec_wr_len = 24'd2; exec_wr = 1'b1;
    idle_cycles(12);
    checks++; if (rx_bit_vld !== 1'b1) begin errors++; $display("FAIL rstmid_ack_pending got %b want 1", rx_bit_vld); end
    rst_n = 1'b0; exec_wr = 1'b0;
    env_cycle();
    checks++; if (tras_cmd_vld !== 1'b0) begin errors++; $display("FAIL rstmid_vld got %b want 0", tras_cmd_vld); end
    checks++; if (tras_cmd !== 3'd0) begin errors++; $display("FAIL rstmid_cmd got %0d want 0", tras_cmd); end
    checks++; if (wfifo_rd_en !== 1'b0) begin errors++; $display("FAIL rstmid_rd_en got %b want 0", wfifo_rd_en); end
    checks++; if (exec_wr_finish !== 1'b0) begin errors++; $display("FAIL rstmid_finish got %b want 0", exec_wr_finish); end
    checks++; if (exec_wr_nack !== 1'b0) begin errors++; $display("FAIL rstmid_nack got %b want 0", exec_wr_nack); end
    checks++; if (bytes_done !== 24'd0) begin errors++; $display("FAIL rstmid_bytes_done got %0d want 0", bytes_done); end
    rst_n = 1'b1;
    idle_cycles(4);
    checks++; if (fin !== 0) begin errors++; $display("FAIL rstmid_no_finish got %0d want 0", fin); end
    fq.delete();
  endtask

  initial begin
    rst_n = 1'b0; exec_wr = 1'b0; exec_wr_len = 24'd0; wfifo_data = 8'h00; wfifo_empty = 1'b1;
    tras_cmd_ready = 1'b1; rx_bit_vld = 1'b0; rx_bit = 1'b0;
    ack_pat = 8'h00; ack_val = 1'b0; rdy_mode = 1'b0; hold_cmd = 3'd0;
    env_clear();
    test_reset();
    test_single_byte();
    test_backpressure();
    test_nack();
    test_empty_stall();
    test_zero_len_retrigger();
    test_abort();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
